// File: rtl/mem_requester.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_requester : initiator-side access unit between datapath and memory, with
//                 a one-entry pending buffer. Optional timeout abort is built
//                 when MEM_REQ_TIMEOUT_EN is defined.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module mem_requester #(
  parameter int ramWidth      = 8,
  parameter int addrSize      = 8,
  parameter int timeoutCycles = 64
) (
  input  logic                clk,
  input  logic                clrN,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic                reqWrite,
  input  logic                reqIndirect,
  input  logic [addrSize-1:0] reqAddr,
  input  logic [ramWidth-1:0] reqData,
  output logic                rspValid,
  output logic [ramWidth-1:0] rspData,
  output logic                rspErr,
  output logic                busy,
  output logic [1:0]          memCntrl,
  output logic [addrSize-1:0] memAddr,
  output logic [ramWidth-1:0] memData,
  output logic                memIndirect,
  input  logic [ramWidth-1:0] memRdData,
  input  logic                memDataReady
);

  typedef struct packed {
    logic                write;
    logic                indirect;
    logic [addrSize-1:0] addr;
    logic [ramWidth-1:0] data;
  } req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  req_t                act_q, act_d;
  req_t                pend_q, pend_d;
  req_t                new_req;
  logic                pend_valid_q, pend_valid_d;
  logic [ramWidth-1:0] rsp_data_q, rsp_data_d;
  logic                accept;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CntW = $clog2(timeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (timeoutCycles > 0);
`endif

  assign new_req  = {reqWrite, reqIndirect, reqAddr, reqData};
  assign reqReady = ~pend_valid_q;
  assign accept   = reqValid & reqReady;
  assign busy     = (state_q != IDLE) | pend_valid_q;
  assign rspValid = (state_q == DONE);
  assign rspData  = rsp_data_q;

  // Memory port is driven straight from state and active registers so an
  // asynchronous reset returns the cache controller to idle immediately.
  assign memCntrl    = (state_q == ACCESS) ? (act_q.write ? 2'b10 : 2'b01) : 2'b00;
  assign memAddr     = act_q.addr;
  assign memData     = act_q.data;
  assign memIndirect = (state_q == ACCESS) & act_q.indirect & ~act_q.write;

`ifdef MEM_REQ_TIMEOUT_EN
  assign rspErr = rsp_err_q;
`else
  assign rspErr = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrN) begin
    if (!clrN) begin
      state_q      <= IDLE;
      act_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      rsp_data_q   <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      rsp_data_q   <= rsp_data_d;
`ifdef MEM_REQ_TIMEOUT_EN
      cnt_q        <= cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    rsp_data_d   = rsp_data_q;
`ifdef MEM_REQ_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = rsp_err_q;
`endif

    // Any accept outside IDLE parks the request; reqReady guarantees the slot is free.
    if (accept && (state_q != IDLE)) begin
      pend_d       = new_req;
      pend_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          act_d        = pend_q;
          pend_valid_d = 1'b0;
          state_d      = ACCESS;
        end else if (accept) begin
          act_d   = new_req;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (memDataReady) begin
          rsp_data_d = act_q.write ? '0 : memRdData;
`ifdef MEM_REQ_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = DONE;
        end
`ifdef MEM_REQ_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(timeoutCycles - 1)) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = DONE;
          end
        end
`endif
      end
      DONE: begin
        if (pend_valid_q) begin
          act_d        = pend_q;
          pend_valid_d = 1'b0;
          state_d      = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef MEM_REQ_TIMEOUT_EN
    if ((state_d == ACCESS) && (state_q != ACCESS)) begin
      cnt_d = '0;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_requester.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_requester : directed bench with a transaction-level scoreboard and a
//                    behavioural memory; honours MEM_REQ_TIMEOUT_EN.
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_mem_requester;

  localparam int TO = 4;

  logic       clk, clrN;
  logic       reqValid, reqReady, reqWrite, reqIndirect;
  logic [7:0] reqAddr, reqData;
  logic       rspValid, rspErr, busy;
  logic [7:0] rspData;
  logic [1:0] memCntrl;
  logic [7:0] memAddr, memData, memRdData;
  logic       memIndirect, memDataReady;

  mem_requester #(
    .ramWidth      (8),
    .addrSize      (8),
    .timeoutCycles (TO)
  ) dut (
    .clk          (clk),
    .clrN         (clrN),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqWrite     (reqWrite),
    .reqIndirect  (reqIndirect),
    .reqAddr      (reqAddr),
    .reqData      (reqData),
    .rspValid     (rspValid),
    .rspData      (rspData),
    .rspErr       (rspErr),
    .busy         (busy),
    .memCntrl     (memCntrl),
    .memAddr      (memAddr),
    .memData      (memData),
    .memIndirect  (memIndirect),
    .memRdData    (memRdData),
    .memDataReady (memDataReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: answers after mem_dly cycles of a held request.
  logic [7:0] mem [256];
  int         mem_dly = 0;
  int         mcnt    = 0;

  always @(posedge clk) begin
    #1;
    if (clrN && memCntrl != 2'b00) begin
      if (mcnt == mem_dly) begin
        memDataReady = 1'b1;
        if (memCntrl == 2'b10) begin
          mem[memAddr] = memData;
          memRdData    = 8'hEE;
        end else begin
          memRdData = memIndirect ? mem[mem[memAddr]] : mem[memAddr];
        end
      end else begin
        memDataReady = 1'b0;
        memRdData    = 8'h00;
      end
      mcnt++;
    end else begin
      mcnt         = 0;
      memDataReady = 1'b0;
      memRdData    = 8'h00;
    end
  end

  // Scoreboard: queue of accepted requests, oldest one is the one on the bus.
  typedef struct {
    logic       wr;
    logic       ind;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  req_t       q[$];
  logic       exp_rsp   = 1'b0;
  logic       exp_issue = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_err   = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       last_err  = 1'b0;
  logic       rsp_now;
  int         acc_cnt   = 0;
  int         rsp_cnt   = 0;
  logic [7:0] log_data[$];
  logic       log_err[$];
  int         log_cyc[$];
  req_t       r;

  always @(negedge clk) begin
    if (!clrN) begin
      chk("rst_memCntrl", memCntrl, 0);
      chk("rst_memAddr", memAddr, 0);
      chk("rst_memData", memData, 0);
      chk("rst_memIndirect", memIndirect, 0);
      chk("rst_rspValid", rspValid, 0);
      chk("rst_rspData", rspData, 0);
      chk("rst_rspErr", rspErr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_reqReady", reqReady, 1);
      q.delete();
      exp_rsp   = 1'b0;
      exp_issue = 1'b0;
      last_data = 8'h00;
      last_err  = 1'b0;
      acc_cnt   = 0;
    end else begin
      chk("rspValid", rspValid, exp_rsp);
      chk("cntrl_legal", memCntrl != 2'b11, 1);
      if (exp_rsp) begin
        chk("rspData", rspData, exp_data);
        chk("rspErr", rspErr, exp_err);
        chk("gap_idle", memCntrl, 0);
        last_data = exp_data;
        last_err  = exp_err;
      end else begin
        chk("rspData_hold", rspData, last_data);
        chk("rspErr_hold", rspErr, last_err);
      end
      if (rspValid) begin
        log_data.push_back(rspData);
        log_err.push_back(rspErr);
        log_cyc.push_back(cyc);
        rsp_cnt++;
      end
      rsp_now = exp_rsp;
      exp_rsp = 1'b0;
      if (exp_issue) chk("issue_next", memCntrl != 2'b00, 1);
      exp_issue = 1'b0;

      chk("busy", busy, q.size() != 0);
      if (q.size() == 0) chk("reqReady_empty", reqReady, 1);
      else if (q.size() >= 2) chk("reqReady_full", reqReady, 0);

      if (memCntrl != 2'b00) begin
        if (q.size() == 0) begin
          chk("spurious_cntrl", memCntrl, 0);
        end else begin
          chk("memCntrl", memCntrl, q[0].wr ? 2'b10 : 2'b01);
          chk("memAddr", memAddr, q[0].addr);
          chk("memIndirect", memIndirect, q[0].ind & ~q[0].wr);
          if (q[0].wr) chk("memData", memData, q[0].data);
          if (memDataReady) begin
            exp_rsp  = 1'b1;
            exp_err  = 1'b0;
            exp_data = q[0].wr ? 8'h00 : (q[0].ind ? mem[mem[q[0].addr]] : mem[q[0].addr]);
          end else begin
            acc_cnt++;
`ifdef MEM_REQ_TIMEOUT_EN
            if (acc_cnt == TO) begin
              exp_rsp  = 1'b1;
              exp_err  = 1'b1;
              exp_data = 8'h00;
            end
`endif
          end
        end
      end else begin
        acc_cnt = 0;
      end

      if (rsp_now && q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() > 0) exp_issue = 1'b1;
      end
      if (reqValid && reqReady) begin
        if (q.size() == 0 && !rsp_now) exp_issue = 1'b1;
        r.wr   = reqWrite;
        r.ind  = reqIndirect;
        r.addr = reqAddr;
        r.data = reqData;
        q.push_back(r);
      end
    end
  end

  int acc_cyc = 0;

  task automatic send(input logic wr, input logic ind, input logic [7:0] a, input logic [7:0] d);
    bit done = 1'b0;
    reqValid    = 1'b1;
    reqWrite    = wr;
    reqIndirect = ind;
    reqAddr     = a;
    reqData     = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (reqReady) begin
        done    = 1'b1;
        acc_cyc = cyc + 1;
      end
      @(posedge clk);
      #1;
    end
    chk("send_accept", done, 1);
  endtask

  task automatic idle_req();
    reqValid    = 1'b0;
    reqWrite    = 1'b0;
    reqIndirect = 1'b0;
    reqAddr     = 8'h00;
    reqData     = 8'h00;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 200 && rsp_cnt < n; i++) @(posedge clk);
    #1;
    chk("rsp_wait", rsp_cnt >= n, 1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2 clrN = 1'b0;
    repeat (n) @(posedge clk);
    #1 clrN = 1'b1;
  endtask

  int base;

  initial begin
    clrN = 1'b0;
    idle_req();
    memDataReady = 1'b0;
    memRdData    = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h12] = 8'hA5;
    mem[8'h20] = 8'h30;
    mem[8'h30] = 8'h77;
    repeat (3) @(posedge clk);
    #1 clrN = 1'b1;
    @(posedge clk); #1;

    // Load 0x12, memory answers 3 cycles after the request appears.
    mem_dly = 3;
    send(1'b0, 1'b0, 8'h12, 8'h00);
    idle_req();
    wait_rsp(1);
    if (rsp_cnt >= 1) begin
      chk("load_data", log_data[0], 8'hA5);
      chk("load_err", log_err[0], 0);
      chk("load_latency", log_cyc[0] - acc_cyc, 4);
    end

    // Store 0x3C to 0x40: response data must be zero.
    mem_dly = 2;
    send(1'b1, 1'b0, 8'h40, 8'h3C);
    idle_req();
    wait_rsp(2);
    if (rsp_cnt >= 2) chk("store_rsp", log_data[1], 8'h00);
    chk("store_mem", mem[8'h40], 8'h3C);

    // Minimum latency: ready on the first access cycle.
    mem_dly = 0;
    send(1'b0, 1'b0, 8'h12, 8'h00);
    idle_req();
    wait_rsp(3);
    if (rsp_cnt >= 3) chk("min_latency", log_cyc[2] - acc_cyc, 1);

    // Back-to-back posting through the pending buffer.
    mem_dly = 1;
    base    = rsp_cnt;
    send(1'b0, 1'b0, 8'h01, 8'h00);
    send(1'b0, 1'b0, 8'h02, 8'h00);
    chk("b2b_ready_low", reqReady, 0);
    send(1'b1, 1'b0, 8'h03, 8'h03);
    idle_req();
    wait_rsp(base + 3);
    if (rsp_cnt >= base + 3) begin
      chk("b2b_rsp0", log_data[base], 8'h5B);
      chk("b2b_rsp1", log_data[base+1], 8'h58);
      chk("b2b_rsp2", log_data[base+2], 8'h00);
    end

    // Indirect load then indirect-flagged store.
    base = rsp_cnt;
    send(1'b0, 1'b1, 8'h20, 8'h00);
    send(1'b1, 1'b1, 8'h50, 8'h11);
    idle_req();
    wait_rsp(base + 2);
    if (rsp_cnt >= base + 2) chk("indirect_load", log_data[base], 8'h77);
    chk("indirect_store_mem", mem[8'h50], 8'h11);

    // Memory never answers.
    mem_dly = 1000;
    base    = rsp_cnt;
    send(1'b0, 1'b0, 8'h60, 8'h00);
    idle_req();
`ifdef MEM_REQ_TIMEOUT_EN
    wait_rsp(base + 1);
    if (rsp_cnt >= base + 1) begin
      chk("timeout_err", log_err[base], 1);
      chk("timeout_data", log_data[base], 8'h00);
      chk("timeout_latency", log_cyc[base] - acc_cyc, TO);
    end
`else
    repeat (20) @(posedge clk);
    #1;
    chk("stuck_busy", busy, 1);
    chk("stuck_no_rsp", rsp_cnt, base);
    do_reset(2);
`endif

    // Reset two cycles into an access with the pending buffer full.
    @(posedge clk); #1;
    send(1'b0, 1'b0, 8'h61, 8'h00);
    send(1'b1, 1'b0, 8'h62, 8'h99);
    idle_req();
    base = rsp_cnt;
    chk("pre_reset_cntrl", memCntrl, 2'b01);
    chk("pre_reset_ready", reqReady, 0);
    #1 clrN = 1'b0;
    #1;
    chk("async_memCntrl", memCntrl, 0);
    chk("async_busy", busy, 0);
    chk("async_reqReady", reqReady, 1);
    chk("async_rspValid", rspValid, 0);
    repeat (2) @(posedge clk);
    #1 clrN = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_no_rsp", rsp_cnt, base);

    mem_dly = 0;
    send(1'b0, 1'b0, 8'h12, 8'h00);
    idle_req();
    wait_rsp(base + 1);
    if (rsp_cnt >= base + 1) chk("post_reset_load", log_data[base], 8'hA5);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_requester.md
# mem_requester

Initiator-side access unit for the cached memory subsystem. It takes load, store and indirect-load requests from the processor datapath over a valid/ready handshake. It drives the memory module's `cntrl`/`addr`/`dataIn`/`isIndirect` port and holds it stable until `dataReady`, then returns read data or an error to the datapath. A one-entry pending buffer lets the datapath post the next request while an access is in flight.

## Interface
- `ramWidth`, 8, data word width
- `addrSize`, 8, address width
- `timeoutCycles`, 64, cycles in ACCESS without `dataReady` before abort (≥2)

- `clk`  in  1  clock, rising edge
- `clrN`  in  1  reset; one clock, reset is asynchronous and active-low
- `reqValid`  in  1  datapath request present
- `reqReady`  out  1  request accepted on edge where `reqValid & reqReady`
- `reqWrite`  in  1  1 = store, 0 = load
- `reqIndirect`  in  1  load through pointer (ignored when `reqWrite`=1)
- `reqAddr`  in  addrSize  request address
- `reqData`  in  ramWidth  store data
- `rspValid`  out  1  one-cycle completion pulse
- `rspData`  out  ramWidth  load data; 0 for stores and errors
- `rspErr`  out  1  timeout abort, valid with `rspValid`
- `busy`  out  1  state ≠ IDLE or pending buffer full
- `memCntrl`  out  2  00 idle, 01 read, 10 write (11 never driven)
- `memAddr`  out  addrSize  to memory `addr`
- `memData`  out  ramWidth  to memory `dataIn`
- `memIndirect`  out  1  to memory `isIndirect`
- `memRdData`  in  ramWidth  from memory `dataOut`
- `memDataReady`  in  1  from memory `dataReady`

## Operation
- Registers: active request (write, indirect, addr, data), pending buffer (same fields + `pendValid`), timeout counter `ceil(log2(timeoutCycles+1))` bits.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: `reqReady`=1. Accept goes to ACCESS with the request latched as active.
- ACCESS: `memCntrl` = 10 if write else 01; `memAddr`/`memData`/`memIndirect` come from the active registers, stable for the whole state. `memIndirect` = indirect & ~write.
  - `memDataReady` sampled 1: capture `memRdData` (0 if write) and go to DONE.
  - Otherwise the counter increments. Reaching `timeoutCycles` goes to DONE with error set and data 0.
- DONE: `memCntrl`=00 (mandatory one-cycle idle gap so the cache controller returns to idle), `rspValid`=1.
  - `pendValid`: move pending to active, clear `pendValid`, go to ACCESS.
  - Else: go to IDLE.
- Outside IDLE: `reqReady` = ~`pendValid`; an accepted request loads the pending buffer.
- In DONE, a same-cycle accept with `pendValid`=1 is impossible (`reqReady`=0). With `pendValid`=0 the new request loads pending and is issued one request later, so order is preserved.
- `memDataReady` is ignored in IDLE and DONE.
- Counter clears on every entry to ACCESS.

## Timing
- Reset (async assert, sync release): state IDLE, `pendValid`=0, `memCntrl`=00, `memAddr`=0, `memData`=0, `memIndirect`=0, `rspValid`=0, `rspData`=0, `rspErr`=0, `busy`=0, `reqReady`=1.
- Reset mid-ACCESS: `memCntrl` drops to 00 asynchronously; the in-flight and pending requests are discarded with no response.
- Accept at edge N: `memCntrl` valid from cycle N+1.
- `memDataReady` high at edge M: `rspValid` high in cycle M+1 with `rspData`/`rspErr`; `memCntrl`=00 in cycle M+1.
- Pending request issue: `memCntrl` active at M+2.
- Minimum request-to-response latency: 2 cycles (ready on first ACCESS cycle).
- `rspData`/`rspErr` hold their values until the next DONE; `rspValid` is a strict single-cycle pulse.

## Configuration
- `MEM_REQ_TIMEOUT_EN` defined: timeout counter and abort path present as above.
- Not defined: counter removed, ACCESS waits indefinitely for `memDataReady`, `rspErr` tied 0, `timeoutCycles` unused.

## Test plan
- Load addr 0x12, memory model returns 0xA5 with `dataReady` 3 cycles after `memCntrl`=01 -> `rspValid` one cycle later, `rspData`=0xA5, `rspErr`=0, `memCntrl`=00 that cycle.
- Store 0x3C to 0x40 -> `memCntrl`=10, `memAddr`=0x40, `memData`=0x3C stable until `dataReady`; response `rspData`=0x00.
- Back-to-back: load 0x01, load 0x02, store 0x03 posted continuously -> `reqReady` low after the second accept until first DONE; three responses in order; `memCntrl`=00 for exactly one cycle between accesses.
- Indirect load 0x20 then indirect store -> `memIndirect`=1 only for the load.
- Timeout (macro on, `timeoutCycles`=4, `dataReady` never asserted) -> `rspValid` with `rspErr`=1, `rspData`=0 after 4 ACCESS cycles; macro off -> no response, `busy` stays 1.
- `clrN` low two cycles into ACCESS with pending full -> all outputs at reset values immediately, no `rspValid`, new request accepted normally after release.
